lsu_memory: RTL

- Parametrised successor to the word-only memory model.
- Single-port, byte-addressed data memory. Supports byte, half, word and full-width accesses, with sign/zero extension on reads and byte-lane masking on writes.
- Fixed, parametrised access latency with a req/ready handshake and a single-cycle response pulse.
- Serves the CPU load/store unit; one outstanding request at a time.

---
 rtl/lsu_memory.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_memory.sv
// lsu_memory: single-port, byte-addressed data memory for the load/store unit.
// One request is accepted at a time through a req/ready handshake. The access
// completes a fixed ACCESS_DELAY cycles later with a one-cycle response pulse.
// Reads are sign- or zero-extended, writes are byte-lane masked, and misaligned
// accesses return an error without touching memory.
module lsu_memory #(
    parameter int NUMWORDS     = 4096,
    parameter int DATAWIDTH    = 32,
    parameter int ACCESS_DELAY = 5,
    localparam int BYTES       = DATAWIDTH / 8,
    localparam int ADDR_SIZE   = $clog2(NUMWORDS * BYTES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 req_ready_o,
    input  logic                 we_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [1:0]           size_i,
    input  logic                 unsigned_i,
    input  logic [DATAWIDTH-1:0] wdata_i,
    output logic                 resp_valid_o,
    output logic [DATAWIDTH-1:0] rdata_o,
    output logic                 err_o
);

    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = ADDR_SIZE - OFF_W;
    localparam int CNT_W = (ACCESS_DELAY > 1) ? $clog2(ACCESS_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_DELAY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Right-aligned bit mask covering the field selected by the access size.
    function automatic logic [DATAWIDTH-1:0] field_mask(input logic [1:0] size);
        logic [DATAWIDTH-1:0] m;
        case (size)
            2'b00:   m = DATAWIDTH'(8'hFF);
            2'b01:   m = DATAWIDTH'(16'hFFFF);
            2'b10:   m = DATAWIDTH'(32'hFFFF_FFFF);
            default: m = '1;
        endcase
        return m;
    endfunction

    // An access is aligned when the lane offset is a multiple of its byte count.
    function automatic logic is_aligned(input logic [OFF_W-1:0] off, input logic [1:0] size);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (off[0] == 1'b0);
            2'b10:   ok = (off[1:0] == 2'b00);
            default: ok = (off == '0);
        endcase
        return ok;
    endfunction

    // Keep the field bits and fill everything above with the field's sign bit,
    // or with zeros for unsigned loads. A full-width field has nothing above it.
    function automatic logic [DATAWIDTH-1:0] extend(input logic [DATAWIDTH-1:0] raw,
                                                    input logic [1:0]           size,
                                                    input logic                 uns);
        logic [DATAWIDTH-1:0] fm;
        logic [DATAWIDTH-1:0] msb;
        logic                 fill;
        fm   = field_mask(size);
        msb  = fm & ~(fm >> 1);
        fill = ~uns & (|(raw & msb));
        return (raw & fm) | ({DATAWIDTH{fill}} & ~fm);
    endfunction

    // Control and response state
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [DATAWIDTH-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

    // Request fields captured at acceptance
    logic                 we_q, we_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [1:0]           size_q, size_d;
    logic                 uns_q, uns_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;

    // Storage and the word update produced at completion
    logic [DATAWIDTH-1:0] mem_q [NUMWORDS];
    logic                 mem_we_d;
    logic [DATAWIDTH-1:0] mem_wdata_d;

    // Derived views of the pending access
    logic [IDX_W-1:0]     idx;
    logic [OFF_W-1:0]     off;
    logic [OFF_W+2:0]     shamt;
    logic [DATAWIDTH-1:0] cur_word;
    logic [DATAWIDTH-1:0] lane_mask;
    logic                 aligned;

    assign idx          = addr_q[ADDR_SIZE-1:OFF_W];
    assign off          = addr_q[OFF_W-1:0];
    assign shamt        = {off, 3'b000};
    assign cur_word     = mem_q[idx];
    assign lane_mask    = field_mask(size_q) << shamt;
    assign aligned      = is_aligned(off, size_q);

    assign req_ready_o  = ready_q;
    assign resp_valid_o = resp_valid_q;
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;

    // Next-state logic: accept in IDLE, count down in BUSY, complete on zero.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        we_d         = we_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = (cur_word & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    wdata_d = wdata_i;
                    cnt_d   = CNT_LOAD;
                    ready_d = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    err_d        = ~aligned;
                    mem_we_d     = aligned & we_q;
                    rdata_d      = (aligned && !we_q)
                                   ? extend(cur_word >> shamt, size_q, uns_q)
                                   : '0;
                    ready_d      = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Register all state; reset abandons any pending access and clears memory.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            mem_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            if (mem_we_d) begin
                mem_q[idx] <= mem_wdata_d;
            end
        end
    end

endmodule
